// File: rtl/icache_ctrl_pkg.sv
// Shared parameters and types for the direct-mapped, read-only instruction cache.
package icache_ctrl_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned ICACHE_SETS   = 64;
  localparam int unsigned ICACHE_LINE_W = 128;
  localparam int unsigned ICACHE_OFF_W  = $clog2(ICACHE_LINE_W / 8);
  localparam int unsigned ICACHE_IDX_W  = $clog2(ICACHE_SETS);
  localparam int unsigned ICACHE_TAG_W  = XLEN - ICACHE_IDX_W - ICACHE_OFF_W;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StRefill,
    StFlush
  } type_icache_states_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            req;
    logic            req_kill;
    logic            icache_flush;
  } type_if2icache_s;

  typedef struct packed {
    logic            ack;
    logic [XLEN-1:0] r_data;
  } type_icache2if_s;

  typedef struct packed {
    logic            req;
    logic [XLEN-1:0] addr;
  } type_icache2mem_s;

  typedef struct packed {
    logic                     ack;
    logic [ICACHE_LINE_W-1:0] data;
  } type_mem2icache_s;

endpackage

// File: rtl/icache_data_array.sv
// Line storage: one synchronous write port for refills, one asynchronous read port.
module icache_data_array #(
  parameter int unsigned Sets  = 64,
  parameter int unsigned LineW = 128
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [$clog2(Sets)-1:0] idx,
  input  logic [LineW-1:0]        wdata,
  output logic [LineW-1:0]        rdata
);

  logic [LineW-1:0] mem_q [Sets];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/icache_ctrl.sv
// Fetch-facing icache controller: tag/valid lookup, line refill over req/ack, flush and kill.
module icache_ctrl
  import icache_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  type_if2icache_s          if2icache_i,
  output type_icache2if_s          icache2if_o,
  output logic                     icache2mem_req_o,
  output logic [XLEN-1:0]          icache2mem_addr_o,
  input  logic                     mem2icache_ack_i,
  input  logic [ICACHE_LINE_W-1:0] mem2icache_data_i
);

  type_icache_states_e state_q, state_d;
  logic [XLEN-1:2]             addr_q, addr_d;
  logic [ICACHE_SETS-1:0]      valid_q, valid_d;
  logic [ICACHE_TAG_W-1:0]     tag_q [ICACHE_SETS];
  logic                        kill_pend_q, kill_pend_d;
  logic                        flush_pend_q, flush_pend_d;
  logic                        mem_req_q, mem_req_d;
  logic [XLEN-1:ICACHE_OFF_W]  mem_addr_q, mem_addr_d;
  logic                        wr_en;
  logic                        ack;
  logic                        hit;
  logic [ICACHE_IDX_W-1:0]     idx;
  logic [ICACHE_TAG_W-1:0]     tag;
  logic [1:0]                  off;
  logic [ICACHE_LINE_W-1:0]    rd_line;
  logic                        unused_addr;

  assign idx = addr_q[ICACHE_OFF_W +: ICACHE_IDX_W];
  assign tag = addr_q[XLEN-1 -: ICACHE_TAG_W];
  assign off = addr_q[3:2];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_addr = ^if2icache_i.addr[1:0];

  icache_data_array #(
    .Sets  (ICACHE_SETS),
    .LineW (ICACHE_LINE_W)
  ) u_data (
    .clk   (clk),
    .we    (wr_en),
    .idx   (idx),
    .wdata (mem2icache_data_i),
    .rdata (rd_line)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    kill_pend_d  = kill_pend_q;
    flush_pend_d = flush_pend_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    wr_en        = 1'b0;
    ack          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (if2icache_i.icache_flush) begin
          state_d = StFlush;
        end else if (if2icache_i.req) begin
          addr_d  = if2icache_i.addr[XLEN-1:2];
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (if2icache_i.icache_flush) begin
          state_d = StFlush;
        end else if (if2icache_i.req_kill || hit) begin
          // A kill only drops the request being looked up; a new one is still accepted.
          ack = ~if2icache_i.req_kill;
          if (if2icache_i.req) begin
            addr_d = if2icache_i.addr[XLEN-1:2];
          end else begin
            state_d = StIdle;
          end
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = addr_q[XLEN-1:ICACHE_OFF_W];
          state_d    = StRefill;
        end
      end
      StRefill: begin
        if (if2icache_i.icache_flush) flush_pend_d = 1'b1;
        if (if2icache_i.req_kill)     kill_pend_d  = 1'b1;
        if (mem2icache_ack_i) begin
          wr_en        = 1'b1;
          valid_d[idx] = 1'b1;
          mem_req_d    = 1'b0;
          kill_pend_d  = 1'b0;
          flush_pend_d = 1'b0;
          if (flush_pend_q || if2icache_i.icache_flush) begin
            state_d = StFlush;
          end else if (kill_pend_q || if2icache_i.req_kill) begin
            state_d = StIdle;
          end else begin
            state_d = StLookup;
          end
        end
      end
      StFlush: begin
        valid_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      valid_q      <= '0;
      kill_pend_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      kill_pend_q  <= kill_pend_d;
      flush_pend_q <= flush_pend_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Tags need no reset: valid bits gate every compare.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[idx] <= tag;
    end
  end

  assign icache2if_o.ack    = ack;
  assign icache2if_o.r_data = ack ? rd_line[{off, 5'b0} +: XLEN] : '0;
  assign icache2mem_req_o   = mem_req_q;
  assign icache2mem_addr_o  = {mem_addr_q, {ICACHE_OFF_W{1'b0}}};

endmodule
